sfx_scheduler: RTL and testbench
================================

Name: sfx_scheduler

Overview:
Arbitrates the single note_gen tone channel between three requesters: the game-over jingle, the jump chirp and live keyboard notes.
Sequences multi-note sound effects from a small ROM using a millisecond tick. Drives note_gen's note_div_left/right and volume.
Sits in dino_top between dino_logic/keyboard decode and note_gen; it replaces the combinational key-to-frequency mux.

Parameters:
TICK_DIV, 100000, clk cycles per duration tick (1 ms at 100 MHz)
VOLUME, 5, default volume code (1..5) driven to note_gen
DIV_W, 22, width of the note divisor output

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-low (0 = reset)
key_note  in  3  live keyboard note code: 0 none, 1..7 = C4..B4
jump_req  in  1  single-cycle pulse; start jump chirp
over_req  in  1  single-cycle pulse; start game-over jingle
mute  in  1  level; force silence without stopping sequencing
note_div  out  DIV_W  divisor to note_gen, both channels; 1 = silence
volume  out  3  volume code to note_gen
busy  out  1  high while a sound effect is playing
sfx_id  out  2  0 none/keyboard, 1 jump, 2 game-over
done  out  1  one-cycle pulse when an effect reaches its end marker

Behaviour:
- All outputs are registered. Reset (rst=0) values: note_div=1, volume=VOLUME, busy=0, sfx_id=0, done=0. Reset also clears the ROM pointer, tick prescaler and duration counter. Reset mid-effect aborts it and raises no done.
- Note codes map to divisors as 100e6/(2f), integer-truncated: 1→190839, 2→170068, 3→151515, 4→143266, 5→127551, 6→113636, 7→101214. Code 0 → 1.
- ROM entry: {note[2:0], dur[7:0]}. A dur of 0 is the end marker.
  - Jump chirp, base address 0: E4/40, G4/40, B4/60, end.
  - Game-over jingle, base address 4: G4/150, E4/150, C4/300 (capped at 255), 0/50 (rest), C4/200, end.
- FSM states:
  - IDLE: note_div follows key_note, 1-cycle latency.
  - LOAD: fetch the ROM entry at the pointer.
  - PLAY: hold the note for dur ticks.
  - FIN: assert done for one cycle, then go to IDLE.
- Request at cycle n: LOAD at n+1; note_div and busy update at n+2.
- On each entry start, the prescaler clears. The note holds exactly dur×TICK_DIV cycles. Then pointer+1 → LOAD.
- Priority: over_req > jump_req > keyboard.
  - over_req preempts a playing jump immediately; that jump raises no done.
  - jump_req during game-over is ignored.
  - jump_req during jump restarts the chirp from address 0.
  - over_req during game-over restarts the jingle.
  - Both requests in the same cycle: the game-over jingle plays.
- key_note is ignored while busy. In IDLE, a key_note change is reflected the next cycle.
- mute=1: note_div=1 the following cycle. Pointer, counters and done are unaffected.
- done fires in FIN; busy drops in the same cycle; sfx_id returns to 0.

Optional Feature:
SFX_VOL_RAMP_EN
- Defined: during the game-over jingle, volume starts at VOLUME and decrements by 1 at each new ROM entry, saturating at 1. It returns to VOLUME in IDLE.
- Undefined: volume is constant VOLUME.
- Jump and keyboard are unaffected in both cases.

Decomposition:
- Package sfx_pkg holds:
  - note code constants NOTE_NONE..NOTE_B4
  - divisor constant table
  - sfx_id encodings SFX_NONE/SFX_JUMP/SFX_OVER
  - ROM base addresses JUMP_BASE=0, OVER_BASE=4
  - the end-marker duration 0
- Sub-module sfx_rom: combinational 16×11 lookup, addr[3:0] → {note, dur}; unused entries are end markers.

Test Plan:
- Reset with rst=0 during jump playback, release → note_div=1, busy=0, volume=5, no done pulse.
- Idle, key_note=6 → note_div=113636 next cycle. Then key_note=0 → note_div=1.
- jump_req pulse with TICK_DIV=10 → note_div 151515 for 400 cycles, 127551 for 400, 101214 for 600, then done pulse. busy high throughout, sfx_id=1.
- jump_req and over_req in the same cycle → sfx_id=2, first note 127551. A later jump_req mid-jingle has no effect. Exactly one done, at jingle end.
- Jump playing, over_req 100 cycles in → note_div=127551 two cycles later. No done for the jump.
- mute=1 mid-jingle → note_div=1 next cycle. done still occurs at the unmuted end time. With SFX_VOL_RAMP_EN, volume runs 5,4,3,2,1 across entries.

Source files
------------

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - note codes, divisor table, effect ids and ROM layout for sfx_scheduler
package sfx_pkg;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_C4   = 3'd1;
  localparam logic [2:0] NOTE_D4   = 3'd2;
  localparam logic [2:0] NOTE_E4   = 3'd3;
  localparam logic [2:0] NOTE_F4   = 3'd4;
  localparam logic [2:0] NOTE_G4   = 3'd5;
  localparam logic [2:0] NOTE_A4   = 3'd6;
  localparam logic [2:0] NOTE_B4   = 3'd7;

  localparam logic [1:0] SFX_NONE = 2'd0;
  localparam logic [1:0] SFX_JUMP = 2'd1;
  localparam logic [1:0] SFX_OVER = 2'd2;

  localparam logic [3:0] JUMP_BASE = 4'd0;
  localparam logic [3:0] OVER_BASE = 4'd4;
  localparam logic [7:0] DUR_END   = 8'd0;

  typedef struct packed {
    logic [2:0] note;
    logic [7:0] dur;
  } rom_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_FIN} state_t;

  // Half-period divisor for a 100 MHz clock: 100e6 / (2 f), truncated; 1 means silence.
  function automatic logic [21:0] note_to_div(input logic [2:0] code);
    case (code)
      NOTE_C4: note_to_div = 22'd190839;
      NOTE_D4: note_to_div = 22'd170068;
      NOTE_E4: note_to_div = 22'd151515;
      NOTE_F4: note_to_div = 22'd143266;
      NOTE_G4: note_to_div = 22'd127551;
      NOTE_A4: note_to_div = 22'd113636;
      NOTE_B4: note_to_div = 22'd101214;
      default: note_to_div = 22'd1;
    endcase
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// rtl/sfx_scheduler_if.sv - request/control inputs and note_gen drive outputs of sfx_scheduler
interface sfx_scheduler_if #(
  parameter int DIV_W = 22
);
  logic [2:0]       key_note;
  logic             jump_req;
  logic             over_req;
  logic             mute;
  logic [DIV_W-1:0] note_div;
  logic [2:0]       volume;
  logic             busy;
  logic [1:0]       sfx_id;
  logic             done;

  modport master (
    output key_note, jump_req, over_req, mute,
    input  note_div, volume, busy, sfx_id, done
  );

  modport slave (
    input  key_note, jump_req, over_req, mute,
    output note_div, volume, busy, sfx_id, done
  );
endinterface

// File: rtl/sfx_rom.sv
// rtl/sfx_rom.sv - 16x11 sound-effect ROM, {note, dur}; dur 0 marks the end of an effect
module sfx_rom
  import sfx_pkg::*;
(
  input  logic [3:0] addr_i,
  output rom_entry_t entry_o
);

  always_comb begin
    entry_o = '{note: NOTE_NONE, dur: DUR_END};
    case (addr_i)
      4'd0: entry_o = '{note: NOTE_E4,   dur: 8'd40};
      4'd1: entry_o = '{note: NOTE_G4,   dur: 8'd40};
      4'd2: entry_o = '{note: NOTE_B4,   dur: 8'd60};
      4'd4: entry_o = '{note: NOTE_G4,   dur: 8'd150};
      4'd5: entry_o = '{note: NOTE_E4,   dur: 8'd150};
      4'd6: entry_o = '{note: NOTE_C4,   dur: 8'd255};
      4'd7: entry_o = '{note: NOTE_NONE, dur: 8'd50};
      4'd8: entry_o = '{note: NOTE_C4,   dur: 8'd200};
      default: entry_o = '{note: NOTE_NONE, dur: DUR_END};
    endcase
  end

endmodule

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - arbitrates jingle/chirp/keyboard onto note_gen; SFX_VOL_RAMP_EN ramps jingle volume
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int          TICK_DIV = 100000,
  parameter int unsigned VOLUME   = 5,
  parameter int          DIV_W    = 22
) (
  input logic           clk,
  input logic           rst,
  sfx_scheduler_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_t           state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [7:0]       dur_q, dur_d;
  logic [DIV_W-1:0] raw_q, raw_d;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       vol_q, vol_d;
  logic             busy_q, busy_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       cur_q, cur_d;
  logic             done_q, done_d;
  rom_entry_t       rom_entry;
  logic             tick, last;
  logic [2:0]       entry_vol;

  sfx_rom u_rom (
    .addr_i  (ptr_q),
    .entry_o (rom_entry)
  );

  // PLAY leaves one cycle early: the LOAD cycle that follows still shows the note, so it lasts dur*TICK_DIV.
  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign last = (dur_q == 8'd1) && (presc_q == PW'(TICK_DIV - 2));

`ifdef SFX_VOL_RAMP_EN
  logic [3:0] ent_off;
  assign ent_off   = ptr_q - OVER_BASE;
  assign entry_vol = (cur_q != SFX_OVER) ? 3'(VOLUME) :
                     (4'(VOLUME) > ent_off + 4'd1) ? 3'(4'(VOLUME) - ent_off) : 3'd1;
`else
  assign entry_vol = 3'(VOLUME);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    presc_d = presc_q;
    dur_d   = dur_q;
    raw_d   = raw_q;
    vol_d   = vol_q;
    busy_d  = busy_q;
    id_d    = id_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    // cur_q tracks the effect being sequenced from the request onward; sfx_id only follows at note start.
    if (bus.over_req) begin
      state_d = S_LOAD;
      ptr_d   = OVER_BASE;
      cur_d   = SFX_OVER;
    end else if (bus.jump_req && (cur_q != SFX_OVER)) begin
      state_d = S_LOAD;
      ptr_d   = JUMP_BASE;
      cur_d   = SFX_JUMP;
    end else begin
      case (state_q)
        S_IDLE: begin
          raw_d = DIV_W'(note_to_div(bus.key_note));
          vol_d = 3'(VOLUME);
        end
        S_LOAD: begin
          if (rom_entry.dur == DUR_END) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            id_d    = SFX_NONE;
            cur_d   = SFX_NONE;
            raw_d   = DIV_W'(1);
            vol_d   = 3'(VOLUME);
          end else begin
            state_d = S_PLAY;
            raw_d   = DIV_W'(note_to_div(rom_entry.note));
            busy_d  = 1'b1;
            id_d    = cur_q;
            dur_d   = rom_entry.dur;
            presc_d = '0;
            vol_d   = entry_vol;
          end
        end
        S_PLAY: begin
          if (last) begin
            state_d = S_LOAD;
            ptr_d   = ptr_q + 4'd1;
          end else if (tick) begin
            presc_d = '0;
            dur_d   = dur_q - 8'd1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      presc_q <= '0;
      dur_q   <= '0;
      raw_q   <= DIV_W'(1);
      div_q   <= DIV_W'(1);
      vol_q   <= 3'(VOLUME);
      busy_q  <= 1'b0;
      id_q    <= SFX_NONE;
      cur_q   <= SFX_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      presc_q <= presc_d;
      dur_q   <= dur_d;
      raw_q   <= raw_d;
      // raw_q keeps the unmuted divisor so un-muting restores the current note immediately.
      div_q   <= bus.mute ? DIV_W'(1) : raw_d;
      vol_q   <= vol_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
    end
  end

  assign bus.note_div = div_q;
  assign bus.volume   = vol_q;
  assign bus.busy     = busy_q;
  assign bus.sfx_id   = id_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - randomized self-checking bench for sfx_scheduler against an effect-timeline model
module tb_sfx_scheduler;

  localparam int T  = 10;
  localparam int DW = 22;
  localparam int NMAX = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfx_scheduler_if #(.DIV_W(DW)) bus ();

  sfx_scheduler #(.TICK_DIV(T), .VOLUME(5), .DIV_W(DW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  // Observed word layout: [28:7] note_div, [6:4] volume, [3] busy, [2:1] sfx_id, [0] done.
  logic [28:0] obs_w [NMAX];
  int sc_e1, sc_e2, sc_p, sc_m0, sc_m1, key_stop;

  function automatic int div_of(input int code);
    case (code)
      1: return 190839;
      2: return 170068;
      3: return 151515;
      4: return 143266;
      5: return 127551;
      6: return 113636;
      7: return 101214;
      default: return 1;
    endcase
  endfunction

  function automatic int n_ent(input int e);
    return (e == 1) ? 3 : 5;
  endfunction

  function automatic int ent_note(input int e, input int i);
    if (e == 1) begin
      case (i) 0: return 3; 1: return 5; default: return 7; endcase
    end
    case (i) 0: return 5; 1: return 3; 2: return 1; 3: return 0; default: return 1; endcase
  endfunction

  function automatic int ent_dur(input int e, input int i);
    if (e == 1) begin
      case (i) 0: return 40; 1: return 40; default: return 60; endcase
    end
    case (i) 0: return 150; 1: return 150; 2: return 255; 3: return 50; default: return 200; endcase
  endfunction

  function automatic int eff_total(input int e);
    int s = 0;
    for (int i = 0; i < n_ent(e); i++) s += ent_dur(e, i) * T;
    return s;
  endfunction

  // Expected outputs at sample c (c = 0 is the first sample showing the first note) plus a volume mask.
  function automatic logic [57:0] expect_at(input int c);
    int e, cc, tot, acc, idx, dv, vol;
    logic bsy, dn, vvalid;
    logic [1:0] id;
    e = sc_e1;
    cc = c;
    if (sc_e2 != 0 && c >= sc_p + 2) begin
      e = sc_e2;
      cc = c - sc_p - 2;
    end else if (sc_e2 != 0 && c == sc_p + 1) begin
      cc = sc_p;
    end
    tot = eff_total(e);
    vol = 5;
    vvalid = 1'b1;
    if (cc < tot) begin
      acc = 0;
      idx = 0;
      while (cc >= acc + ent_dur(e, idx) * T) begin
        acc += ent_dur(e, idx) * T;
        idx++;
      end
      dv = div_of(ent_note(e, idx));
      bsy = 1'b1;
      id = 2'(e);
      dn = 1'b0;
`ifdef SFX_VOL_RAMP_EN
      if (e == 2) vol = (5 - idx < 1) ? 1 : 5 - idx;
`endif
    end else begin
      dv = 1;
      bsy = 1'b0;
      id = 2'd0;
      dn = (cc == tot);
`ifdef SFX_VOL_RAMP_EN
      vvalid = (cc != tot);
`endif
    end
    if (c >= 1 && (c - 1) >= sc_m0 && (c - 1) < sc_m1) dv = 1;
    return {{22'(dv), 3'(vol), bsy, id, dn}, {22'h3fffff, vvalid ? 3'b111 : 3'b000, 4'hf}};
  endfunction

  task automatic start_effect(input logic j, input logic o);
    @(negedge clk);
    bus.jump_req = j;
    bus.over_req = o;
    @(negedge clk);
    bus.jump_req = 1'b0;
    bus.over_req = 1'b0;
  endtask

  // Records n samples while driving mute, keyboard noise and an optional second request (k2) at sc_p.
  task automatic capture(input int n, input int k2);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      obs_w[c] = {bus.note_div, bus.volume, bus.busy, bus.sfx_id, bus.done};
      bus.mute     = (c >= sc_m0 && c < sc_m1);
      bus.jump_req = (k2 == 1 && c == sc_p);
      bus.over_req = (k2 == 2 && c == sc_p);
      bus.key_note = (c < key_stop) ? 3'($urandom_range(0, 7)) : 3'd0;
    end
    bus.mute = 1'b0;
    bus.jump_req = 1'b0;
    bus.over_req = 1'b0;
    bus.key_note = 3'd0;
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(negedge clk);
    checks++; if (bus.note_div !== 22'd1) $display("FAIL reset_div: got %0d want 1", bus.note_div); else passed++;
    checks++; if (bus.volume !== 3'd5) $display("FAIL reset_vol: got %0d want 5", bus.volume); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.sfx_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", bus.sfx_id); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    rst_n = 1'b1;
    start_effect(1'b1, 1'b0);
    repeat (150) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.note_div !== 22'd1 || bus.busy !== 1'b0)
      $display("FAIL async_reset: div=%0d busy=%b want div=1 busy=0", bus.note_div, bus.busy); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.note_div !== 22'd1 || bus.volume !== 3'd5) bad++;
    end
    checks++; if (bad != 0) $display("FAIL reset_abort: %0d non-idle cycles after mid-jump reset, want 0", bad); else passed++;
  endtask

  task automatic test_keyboard();
    int k, m, want;
    for (int i = 0; i < 14; i++) begin
      k = (i == 0) ? 6 : (i == 13) ? 0 : int'($urandom_range(0, 7));
      m = (i > 1 && i < 13 && $urandom_range(0, 3) == 0) ? 1 : 0;
      bus.key_note = 3'(k);
      bus.mute = m[0];
      @(negedge clk);
      want = m ? 1 : div_of(k);
      checks++;
      if (bus.note_div !== 22'(want)) $display("FAIL key_%0d: key=%0d mute=%0d got %0d want %0d", i, k, m, bus.note_div, want);
      else passed++;
    end
    bus.mute = 1'b0;
    bus.key_note = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_jump();
    int n, bad, fc, nd, n_e, n_g, n_b;
    logic [57:0] ex;
    sc_e1 = 1; sc_e2 = 0; sc_p = -10; sc_m0 = 0; sc_m1 = 0;
    n = eff_total(1) + 4;
    key_stop = eff_total(1) - 5;
    start_effect(1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b0 || bus.note_div !== 22'd1)
      $display("FAIL jump_load_cycle: busy=%b div=%0d want busy=0 div=1", bus.busy, bus.note_div); else passed++;
    capture(n, 0);
    key_stop = 0;
    bad = 0; fc = 0; nd = 0; n_e = 0; n_g = 0; n_b = 0;
    for (int c = 0; c < n; c++) begin
      ex = expect_at(c);
      if ((obs_w[c] & ex[28:0]) !== (ex[57:29] & ex[28:0])) begin if (bad == 0) fc = c; bad++; end
      if (obs_w[c][0]) nd++;
      if (obs_w[c][28:7] == 22'd151515) n_e++;
      if (obs_w[c][28:7] == 22'd127551) n_g++;
      if (obs_w[c][28:7] == 22'd101214) n_b++;
    end
    ex = expect_at(fc);
    checks++; if (bad != 0) $display("FAIL jump_trace: cycle %0d got %h want %h (%0d bad)", fc, obs_w[fc], ex[57:29], bad); else passed++;
    checks++; if (nd != 1) $display("FAIL jump_done_count: got %0d want 1", nd); else passed++;
    checks++; if (n_e != 400 || n_g != 400 || n_b != 600)
      $display("FAIL jump_note_lengths: got %0d/%0d/%0d want 400/400/600", n_e, n_g, n_b); else passed++;
  endtask

  task automatic test_over_both();
    int n, bad, fc, nd;
    logic [57:0] ex;
    sc_e1 = 2; sc_e2 = 0;
    sc_p = int'($urandom_range(100, 7000));
    sc_m0 = int'($urandom_range(1000, 6000));
    sc_m1 = sc_m0 + int'($urandom_range(50, 500));
    n = eff_total(2) + 4;
    start_effect(1'b1, 1'b1);
    capture(n, 1);
    bad = 0; fc = 0; nd = 0;
    for (int c = 0; c < n; c++) begin
      ex = expect_at(c);
      if ((obs_w[c] & ex[28:0]) !== (ex[57:29] & ex[28:0])) begin if (bad == 0) fc = c; bad++; end
      if (obs_w[c][0]) nd++;
    end
    ex = expect_at(fc);
    checks++; if (obs_w[0][28:7] !== 22'd127551 || obs_w[0][2:1] !== 2'd2)
      $display("FAIL both_first_note: div=%0d id=%0d want 127551 id 2", obs_w[0][28:7], obs_w[0][2:1]); else passed++;
    checks++; if (bad != 0) $display("FAIL over_trace: p=%0d mute=%0d..%0d cycle %0d got %h want %h (%0d bad)",
      sc_p, sc_m0, sc_m1, fc, obs_w[fc], ex[57:29], bad); else passed++;
    checks++; if (nd != 1) $display("FAIL over_done_count: got %0d want 1", nd); else passed++;
  endtask

  task automatic test_preempt(input int p);
    int n, bad, fc, nd;
    logic [57:0] ex;
    sc_e1 = 1; sc_e2 = 2; sc_p = p; sc_m0 = 0; sc_m1 = 0;
    n = p + 2 + eff_total(2) + 4;
    start_effect(1'b1, 1'b0);
    capture(n, 2);
    bad = 0; fc = 0; nd = 0;
    for (int c = 0; c < n; c++) begin
      ex = expect_at(c);
      if ((obs_w[c] & ex[28:0]) !== (ex[57:29] & ex[28:0])) begin if (bad == 0) fc = c; bad++; end
      if (obs_w[c][0]) nd++;
    end
    ex = expect_at(fc);
    checks++; if (obs_w[p + 2][28:7] !== 22'd127551)
      $display("FAIL preempt_first_note: p=%0d got %0d want 127551", p, obs_w[p + 2][28:7]); else passed++;
    checks++; if (bad != 0) $display("FAIL preempt_trace: p=%0d cycle %0d got %h want %h (%0d bad)",
      p, fc, obs_w[fc], ex[57:29], bad); else passed++;
    checks++; if (nd != 1) $display("FAIL preempt_done_count: got %0d want 1", nd); else passed++;
  endtask

  task automatic test_restart();
    int n, bad, fc, nd;
    logic [57:0] ex;
    sc_e1 = 1; sc_e2 = 1;
    sc_p = int'($urandom_range(20, 1350));
    sc_m0 = int'($urandom_range(0, 1500));
    sc_m1 = sc_m0 + int'($urandom_range(1, 300));
    n = sc_p + 2 + eff_total(1) + 4;
    start_effect(1'b1, 1'b0);
    capture(n, 1);
    bad = 0; fc = 0; nd = 0;
    for (int c = 0; c < n; c++) begin
      ex = expect_at(c);
      if ((obs_w[c] & ex[28:0]) !== (ex[57:29] & ex[28:0])) begin if (bad == 0) fc = c; bad++; end
      if (obs_w[c][0]) nd++;
    end
    ex = expect_at(fc);
    checks++; if (bad != 0) $display("FAIL restart_trace: p=%0d mute=%0d..%0d cycle %0d got %h want %h (%0d bad)",
      sc_p, sc_m0, sc_m1, fc, obs_w[fc], ex[57:29], bad); else passed++;
    checks++; if (nd != 1) $display("FAIL restart_done_count: got %0d want 1", nd); else passed++;
  endtask

  initial begin
    bus.key_note = 3'd0;
    bus.jump_req = 1'b0;
    bus.over_req = 1'b0;
    bus.mute     = 1'b0;
    key_stop     = 0;
    test_reset();
    test_keyboard();
    test_jump();
    test_over_both();
    test_preempt(100);
    test_preempt(int'($urandom_range(20, 1350)));
    test_restart();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
